midi_tx: RTL
============

# midi_tx

Serial MIDI transmitter: the transmit-side counterpart of the MIDI UART decoder. Accepts one channel-voice message per valid/ready handshake and serializes it at 31250 baud (8N1, LSB first) onto a MIDI OUT pin. Running-status compression is optional. Sits beside the synth driver and can echo or generate note events to external gear.

## Interface
- `CLKS_PER_BIT`, default 1600: i_clk cycles per bit (50 MHz / 31250). Minimum 4.
- `RUNNING_STATUS`, default 1: 1 = omit the status byte when it repeats; 0 = always send it.
- `i_clk` in, 1: system clock.
- `i_nrst` in, 1: reset, asynchronous, active-low.
- `i_valid` in, 1: message on `i_status`/`i_data1`/`i_data2` is valid.
- `o_ready` out, 1: block can accept a message (IDLE only).
- `i_status` in, 8: status byte; must be 0x80–0xEF.
- `i_data1` in, 8: first data byte; bit 7 forced to 0 on transmit.
- `i_data2` in, 8: second data byte; bit 7 forced to 0; ignored for 2-byte messages.
- `o_serial` out, 1: MIDI line; idle high.
- `o_busy` out, 1: frame in progress.
- `o_msg_done` out, 1: 1-cycle pulse when the last stop bit completes.
- `o_err` out, 1: 1-cycle pulse when a message is rejected.

## Operation
- States: IDLE, START, DATA, STOP.
- Accept: `i_valid && o_ready`. Inputs are latched on that edge; later input changes are ignored.
- Message length:
  - high nibble 0xC or 0xD: status + 1 data byte.
  - 0x8, 0x9, 0xA, 0xB, 0xE: status + 2 data bytes.
- Reject: `i_status[7]==0` or high nibble 0xF. On reject, `o_err` pulses the cycle after accept, there is no line activity, the block stays in IDLE, and running status is unchanged.
- Running status:
  - A register holds the last transmitted status plus a valid flag; both are cleared on reset.
  - If `RUNNING_STATUS==1`, the flag is set, and `i_status` equals the stored status, the status byte is skipped.
  - Otherwise the status byte is sent and the register is updated.
- Byte queue, in send order: [status], data1, [data2]. The byte counter starts at the first byte that will actually be sent.
- Per byte:
  - START: `o_serial`=0 for one bit time.
  - DATA: 8 bits, LSB first, one bit time each.
  - STOP: `o_serial`=1 for one bit time.
- Bytes are sent back-to-back: the next START follows STOP directly, with no idle gap.
- After the final STOP: `o_msg_done` pulses, the FSM returns to IDLE, and `o_ready` rises.
- `o_ready` = (state==IDLE) and no `o_err` pulse pending.

## Timing
- Reset values: `o_serial`=1, `o_ready`=1, `o_busy`=0, `o_msg_done`=0, `o_err`=0, FSM in IDLE, bit-timer=0, running status invalid.
- Reset is asynchronous. Asserting it mid-frame forces `o_serial` high immediately and abandons the message. The first message after reset always sends its status byte.
- Latency: `o_serial` falls on the first rising edge after the accept edge, and `o_busy` rises on that same edge.
- Bit time is exactly `CLKS_PER_BIT` cycles, counted by a `$clog2(CLKS_PER_BIT)`-bit down-counter. It reloads at each bit boundary, with no drift across bytes.
- Frame lengths:
  - 3-byte message: 30 × `CLKS_PER_BIT` cycles.
  - 2-byte, or 3-byte with status skipped: 20 × `CLKS_PER_BIT` cycles.
  - 2-byte with status skipped: 10 × `CLKS_PER_BIT` cycles.
- `o_msg_done` is asserted in the last cycle of the final stop bit. `o_ready` is high on the next cycle, so a new accept there yields zero idle gap between messages.
- `o_busy` stays high from the first start bit through the final stop bit, including between bytes.
- `i_valid` while not ready: no effect. The source must hold its data until the handshake.

## Test plan
(Benches use `CLKS_PER_BIT`=16.)
- Reset then note-on: send 0x90/0x3C/0x64.
  - Expect 480 cycles of frames carrying bytes 0x90, 0x3C, 0x64 (start 0, LSB first, stop 1).
  - Expect `o_msg_done` at cycle 480 and `o_ready` high at 481.
- Running status: send 0x90/0x3E/0x00 immediately after.
  - Expect only 0x3E, 0x00 (320 cycles).
  - With `RUNNING_STATUS`=0: 0x90, 0x3E, 0x00 (480 cycles).
- Two-byte message and status change: 0xC0/0x05 → 0xC0, 0x05 (320 cycles). Then 0x80/0x3C/0x40 → all three bytes sent.
- Reject: `i_status`=0x3C, then 0xF8.
  - Each gives one `o_err` pulse, `o_serial` stays 1, and `o_busy` stays 0.
  - A following 0x90 message still uses the prior running status.
- Reset mid-frame: assert `i_nrst` low at cycle 100 of a message.
  - `o_serial` goes to 1 asynchronously and outputs take reset values.
  - The next 0x90 message sends its status byte.
- Data masking and handshake:
  - 0x90/0xBC/0xFF transmits 0x3C, 0x7F.
  - Toggling `i_valid` and the inputs during a frame changes nothing on the line.

Source files
------------

// File: rtl/midi_tx.sv
// MIDI transmitter: accepts one channel-voice message per valid/ready handshake and
// serializes it 8N1, LSB first, onto the MIDI OUT line. Running status is optional.
//
// Ports:
//   i_clk, i_nrst      clock, asynchronous active-low reset
//   i_valid / o_ready  message handshake (ready only in idle with no error pending)
//   i_status           status byte, 0x80-0xEF accepted
//   i_data1, i_data2   data bytes, bit 7 masked on transmit; i_data2 unused for 0xC/0xD
//   o_serial           MIDI line, idle high
//   o_busy             high from first start bit through final stop bit
//   o_msg_done         pulse in the last cycle of the final stop bit
//   o_err              pulse the cycle after a rejected message is accepted
module midi_tx #(
  parameter int unsigned CLKS_PER_BIT   = 1600,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_status,
  input  logic [7:0] i_data1,
  input  logic [7:0] i_data2,
  output logic       o_serial,
  output logic       o_busy,
  output logic       o_msg_done,
  output logic       o_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [1:0]        last_q, last_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [7:0]        rs_status_q, rs_status_d;
  logic              rs_vld_q, rs_vld_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       accept, msg_bad, two_byte, skip_status;
  logic [2:0] bit_nx;
  logic [7:0] cur_byte;

  assign accept      = i_valid && o_ready;
  assign msg_bad     = !i_status[7] || (i_status[7:4] == 4'hF);
  assign two_byte    = (i_status[7:4] == 4'hC) || (i_status[7:4] == 4'hD);
  assign skip_status = (RUNNING_STATUS != 0) && rs_vld_q && (rs_status_q == i_status);
  assign bit_nx      = bit_q + 3'd1;

  // Byte slots are status/data1/data2; byte_q walks from the first byte actually sent.
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = b0_q;
      2'd1:    cur_byte = b1_q;
      default: cur_byte = b2_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    last_d      = last_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    rs_status_d = rs_status_q;
    rs_vld_d    = rs_vld_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        if (accept) begin
          if (msg_bad) begin
            err_d = 1'b1;
          end else begin
            b0_d   = i_status;
            b1_d   = i_data1 & 8'h7F;
            b2_d   = i_data2 & 8'h7F;
            byte_d = skip_status ? 2'd1 : 2'd0;
            last_d = two_byte ? 2'd1 : 2'd2;
            if (!skip_status) begin
              rs_status_d = i_status;
              rs_vld_d    = 1'b1;
            end
            state_d  = StStart;
            cnt_d    = Reload;
            serial_d = 1'b0;
          end
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d  = StData;
          cnt_d    = Reload;
          bit_d    = 3'd0;
          serial_d = cur_byte[0];
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = Reload;
          if (bit_q == 3'd7) begin
            state_d  = StStop;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_nx;
            serial_d = cur_byte[bit_nx];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        // Registered pulse lands in the final cycle of the last stop bit.
        if ((cnt_q == CntW'(1)) && (byte_q == last_q)) done_d = 1'b1;
        if (cnt_q == '0) begin
          if (byte_q == last_q) begin
            state_d = StIdle;
          end else begin
            byte_d   = byte_q + 2'd1;
            state_d  = StStart;
            cnt_d    = Reload;
            serial_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      last_q      <= 2'd0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      b2_q        <= 8'h00;
      rs_status_q <= 8'h00;
      rs_vld_q    <= 1'b0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      rs_status_q <= rs_status_d;
      rs_vld_q    <= rs_vld_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_serial   = serial_q;
  assign o_busy     = (state_q != StIdle);
  assign o_ready    = (state_q == StIdle) && !err_q;
  assign o_msg_done = done_q;
  assign o_err      = err_q;

endmodule
